// File: rtl/var_delay_pkg.sv
// var_delay_pkg: width and latency-clamp helpers for the programmable delay line.
// VAR_DELAY_ZERO_LAT_EN lowers the minimum latency from 1 to 0 (pass-through).
package var_delay_pkg;
   function automatic int clog2(input int n);
      int r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic int lat_width(input int max_lat);
      return clog2(max_lat + 1);
   endfunction
   function automatic int clamp_lat(input int lat, input int max_lat);
`ifdef VAR_DELAY_ZERO_LAT_EN
      return lat > max_lat ? max_lat : lat;
`else
      return lat < 1 ? 1 : lat > max_lat ? max_lat : lat;
`endif
   endfunction
endpackage

// File: rtl/var_delay_ram.sv
// var_delay_ram: simple dual-port buffer with read-first registered read.
// Only the read register is reset; the array is not.
module var_delay_ram #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 15,
   parameter int AW    = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [AW-1:0]    raddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;
   always_ff @(posedge clk_i)
      if (en_i) mem_q[waddr_i] <= wdata_i;
   always_ff @(posedge clk_i)
      if (rst_i) rdata_q <= '0;
      else if (en_i) rdata_q <= mem_q[raddr_i];
   assign rdata_o = rdata_q;
endmodule

// File: rtl/var_delay.sv
// var_delay: run-time programmable delay line with priming tracking.
// VAR_DELAY_ZERO_LAT_EN enables latency 0 as combinational pass-through.
module var_delay
   import var_delay_pkg::*;
#(
   parameter int BIT_WIDTH   = 8,
   parameter int CHANNELS    = 1,
   parameter int MAX_LATENCY = 16,
   localparam int LAT_W      = lat_width(MAX_LATENCY),
   localparam int DW         = CHANNELS * BIT_WIDTH
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             enable,
   input  logic [LAT_W-1:0] latency,
   input  logic             in_valid,
   input  logic [DW-1:0]    in_data,
   output logic             out_valid,
   output logic [DW-1:0]    out_data,
   output logic             lat_ok
);
   localparam int D  = MAX_LATENCY - 1;
   localparam int PW = clog2(D);
   logic [LAT_W-1:0] lat_req, cur_lat_q, cur_lat_d, fill_q, fill_d;
   logic [PW-1:0]    wp_q, wp_d, ra;
   logic             chg, prime_q, prime_d;
   logic [DW:0]      byp_q, byp_d, rd, sel;
   int               ra_i;
   always_comb begin
      lat_req   = LAT_W'(clamp_lat(int'(latency), MAX_LATENCY));
      chg       = lat_req != cur_lat_q;
      cur_lat_d = enable ? lat_req : cur_lat_q;
      fill_d    = !enable ? fill_q : chg ? '0 : fill_q == cur_lat_q ? fill_q : fill_q + 1'b1;
      // output may go valid once this edge completes L enabled edges since the last restart
      prime_d   = enable ? !chg && (({1'b0, fill_q} + 1'b1) >= {1'b0, cur_lat_q}) : prime_q;
      wp_d      = !enable ? wp_q : wp_q == PW'(D - 1) ? '0 : wp_q + 1'b1;
      byp_d     = enable ? {in_valid, in_data} : byp_q;
      ra_i      = int'(wp_q) + D + 1 - int'(cur_lat_q);
      ra        = PW'(ra_i >= D ? ra_i - D : ra_i);
      sel       = cur_lat_q == LAT_W'(1) ? byp_q : rd;
   end
   always_ff @(posedge clock) begin
      if (rst) begin
         cur_lat_q <= lat_req;
         fill_q    <= '0;
         prime_q   <= 1'b0;
         wp_q      <= '0;
         byp_q     <= '0;
      end else begin
         cur_lat_q <= cur_lat_d;
         fill_q    <= fill_d;
         prime_q   <= prime_d;
         wp_q      <= wp_d;
         byp_q     <= byp_d;
      end
   end
   var_delay_ram #(.WIDTH(DW + 1), .DEPTH(D), .AW(PW)) u_ram (
      .clk_i   (clock),
      .rst_i   (rst),
      .en_i    (enable),
      .waddr_i (wp_q),
      .raddr_i (ra),
      .wdata_i ({in_valid, in_data}),
      .rdata_o (rd)
   );
`ifdef VAR_DELAY_ZERO_LAT_EN
   logic zero;
   assign zero      = cur_lat_q == '0;
   assign out_data  = zero ? in_data : sel[DW-1:0];
   assign out_valid = zero ? in_valid : sel[DW] & prime_q;
   assign lat_ok    = zero | (fill_q == cur_lat_q);
`else
   assign out_data  = sel[DW-1:0];
   assign out_valid = sel[DW] & prime_q;
   assign lat_ok    = fill_q == cur_lat_q;
`endif
endmodule
